// File: rtl/sle_rdbk_pkg.sv
// -----------------------------------------------------------------------------
// sle_rdbk_pkg
//
// Shared definitions for the SLE readback engine.
//   sle_rdbk_state_t     - FSM state encoding. PAR exists in the encoding in
//                          every build. It is only reachable when the parity
//                          option is compiled in.
//   sle_rdbk_frame_len() - number of serial bits in one frame for a given
//                          bank width. This is the data bits plus one parity
//                          bit when the option is enabled.
//
// Configuration macro: SLE_RDBK_PARITY_EN. When defined, each frame carries a
// trailing even-parity bit.
// -----------------------------------------------------------------------------
package sle_rdbk_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FREEZE  = 3'd1,
        CAPTURE = 3'd2,
        SHIFT   = 3'd3,
        PAR     = 3'd4,
        DONE    = 3'd5
    } sle_rdbk_state_t;

    function automatic int sle_rdbk_frame_len(input int width);
`ifdef SLE_RDBK_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/sle_rdbk_shifter.sv
// -----------------------------------------------------------------------------
// sle_rdbk_shifter
//
// Shadow register and bit counter for the SLE readback engine.
// A load copies the bank snapshot into the shadow register and clears the
// counter. Each shift moves the shadow right by one bit, fills the top with
// zero, and increments the counter. The current serial bit is always
// shadow[0].
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset; clears shadow and counter
//   load     in   capture q_in into the shadow and clear the counter
//   shift    in   advance one bit (ignored while load is high)
//   q_in     in   WIDTH-bit parallel snapshot source
//   bit_out  out  current serial bit (shadow[0])
//   is_last  out  counter points at the final data bit (WIDTH-1)
//   parity   out  even parity of the captured word
//                 (only present when SLE_RDBK_PARITY_EN is defined)
//
// Configuration macro: SLE_RDBK_PARITY_EN adds the parity register and port.
// -----------------------------------------------------------------------------
module sle_rdbk_shifter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] q_in,
    output logic             bit_out,
`ifdef SLE_RDBK_PARITY_EN
    output logic             parity,
`endif
    output logic             is_last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shadow;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            cnt    <= '0;
        end else if (load) begin
            shadow <= q_in;
            cnt    <= '0;
        end else if (shift) begin
            shadow <= {1'b0, shadow[WIDTH-1:1]};
            cnt    <= cnt + CNT_W'(1);
        end
    end

`ifdef SLE_RDBK_PARITY_EN
    // The shadow is consumed while shifting. Parity is therefore taken from
    // q_in at load time and held for the trailing bit.
    logic par_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit <= 1'b0;
        end else if (load) begin
            par_bit <= ^q_in;
        end
    end

    assign parity = par_bit;
`endif

    assign bit_out = shadow[0];
    assign is_last = (cnt == LAST_CNT);

endmodule

// File: rtl/sle_readback.sv
// -----------------------------------------------------------------------------
// sle_readback
//
// Serial readback engine for a bank of SLE storage elements.
// On a request, the engine:
//   1. freezes the bank for one cycle;
//   2. snapshots Q into a shadow register while still frozen;
//   3. releases the bank;
//   4. streams the snapshot LSB-first over a valid/ready serial link.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset; aborts any frame
//   cap_req   in   readback request, honoured only in IDLE
//   q_in      in   WIDTH-bit Q outputs of the SLE bank
//   freeze    out  high in FREEZE and CAPTURE (bank En forced low)
//   busy      out  high in every state except IDLE
//   sd_out    out  serial data bit
//   sd_valid  out  sd_out carries a bit
//   sd_ready  in   sink ready
//   sd_last   out  final bit of the frame
//   done      out  one-cycle pulse after the last bit is accepted
//
// Handshake: a bit transfers on a rising edge where sd_valid and sd_ready are
// both high. Once sd_valid is raised, sd_valid, sd_out and sd_last hold
// stable until that transfer occurs. The sink may drive sd_ready freely.
//
// The FSM state is held in the signal `state` (type sle_rdbk_state_t) for
// hierarchical observation.
//
// Configuration macro: SLE_RDBK_PARITY_EN appends an even-parity bit (PAR
// state). sd_last then marks the parity bit instead of data bit WIDTH-1.
// -----------------------------------------------------------------------------
module sle_readback
    import sle_rdbk_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_req,
    input  logic [WIDTH-1:0] q_in,
    output logic             freeze,
    output logic             busy,
    output logic             sd_out,
    output logic             sd_valid,
    input  logic             sd_ready,
    output logic             sd_last,
    output logic             done
);

    sle_rdbk_state_t state;
    sle_rdbk_state_t state_nxt;

    logic load;
    logic shift;
    logic bit_out;
    logic is_last;
`ifdef SLE_RDBK_PARITY_EN
    logic parity;
`endif

    // -------------------------------------------------------------------------
    // Shadow register and bit counter
    // -------------------------------------------------------------------------
    sle_rdbk_shifter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .shift   (shift),
        .q_in    (q_in),
        .bit_out (bit_out),
`ifdef SLE_RDBK_PARITY_EN
        .parity  (parity),
`endif
        .is_last (is_last)
    );

    // The snapshot is taken on the edge that leaves CAPTURE. The bank has
    // been frozen for the whole preceding cycle, so q_in is settled.
    assign load  = (state == CAPTURE);
    assign shift = (state == SHIFT) && sd_ready;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. cap_req is looked at only in IDLE, so a request held
    // through a frame (including its DONE cycle) cannot start a second one.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cap_req) begin
                    state_nxt = FREEZE;
                end
            end
            FREEZE: begin
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (sd_ready && is_last) begin
`ifdef SLE_RDBK_PARITY_EN
                    state_nxt = PAR;
`else
                    state_nxt = DONE;
`endif
                end
            end
            PAR: begin
                if (sd_ready) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs are decoded from the registered state and shadow only. Reset
    // therefore zeroes them on the same edge, and they cannot change while
    // the sink stalls: neither state nor shadow moves without a handshake.
    // -------------------------------------------------------------------------
    always_comb begin
        freeze   = 1'b0;
        busy     = 1'b1;
        sd_out   = 1'b0;
        sd_valid = 1'b0;
        sd_last  = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
            end
            FREEZE, CAPTURE: begin
                freeze = 1'b1;
            end
            SHIFT: begin
                sd_valid = 1'b1;
                sd_out   = bit_out;
`ifndef SLE_RDBK_PARITY_EN
                sd_last  = is_last;
`endif
            end
`ifdef SLE_RDBK_PARITY_EN
            PAR: begin
                sd_valid = 1'b1;
                sd_out   = parity;
                sd_last  = 1'b1;
            end
`endif
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sle_readback.sv
// -----------------------------------------------------------------------------
// tb_sle_readback
//
// Directed plus randomized bench for sle_readback (WIDTH=16).
// Inputs are driven on the falling edge and outputs are sampled there.
// The reference model is the list of bits a frame must carry: data bits
// LSB-first, plus the XOR of the word when SLE_RDBK_PARITY_EN is defined.
// Cycle expectations are counted from the edge that samples cap_req.
// -----------------------------------------------------------------------------
module tb_sle_readback;
    import sle_rdbk_pkg::*;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         cap_req;
    logic [W-1:0] q_in;
    logic         freeze;
    logic         busy;
    logic         sd_out;
    logic         sd_valid;
    logic         sd_ready;
    logic         sd_last;
    logic         done;

    int checks;
    int errors;
    logic exp_q[$];

    sle_readback #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .cap_req  (cap_req),
        .q_in     (q_in),
        .freeze   (freeze),
        .busy     (busy),
        .sd_out   (sd_out),
        .sd_valid (sd_valid),
        .sd_ready (sd_ready),
        .sd_last  (sd_last),
        .done     (done)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_freeze"},   freeze,   1'b0);
        chk({tag, "_busy"},     busy,     1'b0);
        chk({tag, "_sd_out"},   sd_out,   1'b0);
        chk({tag, "_sd_valid"}, sd_valid, 1'b0);
        chk({tag, "_sd_last"},  sd_last,  1'b0);
        chk({tag, "_done"},     done,     1'b0);
    endtask

    // Runs one frame starting at a falling edge in IDLE.
    //   mode        0: sd_ready always 1
    //               1: sd_ready pattern 1,0,0,...
    //               2: random sd_ready
    //   hold        keep cap_req high through the whole frame
    //   abort_after >0: assert rst once this many bits have been accepted
    task automatic run_frame(input logic [W-1:0] word, input int mode,
                             input bit hold, input int abort_after);
        int   c;
        int   accepted;
        bit   done_next;
        bit   seen_done;
        bit   rdy;
        logic exp_valid;

        exp_q.delete();
        for (int i = 0; i < W; i++) exp_q.push_back(word[i]);
`ifdef SLE_RDBK_PARITY_EN
        exp_q.push_back(^word);
`endif
        cap_req   = 1'b1;
        q_in      = W'($urandom);
        sd_ready  = 1'b0;
        c         = 0;
        accepted  = 0;
        done_next = 1'b0;
        seen_done = 1'b0;

        while (!seen_done && c < 400) begin
            @(negedge clk);
            c++;
            if (abort_after > 0 && accepted == abort_after) begin
                rst      = 1'b1;
                cap_req  = 1'b0;
                sd_ready = 1'b0;
                @(negedge clk);
                chk_outputs_zero("rst_abort");
                rst = 1'b0;
                @(negedge clk);
                chk_outputs_zero("post_abort");
                return;
            end
            exp_valid = (c >= 3) && (exp_q.size() != 0);
            chk("busy", busy, 1'b1);
            chk("freeze", freeze, (c == 1 || c == 2));
            chk("done", done, done_next);
            chk("sd_valid", sd_valid, exp_valid);
            if (exp_valid) begin
                chk("sd_out", sd_out, exp_q[0]);
                chk("sd_last", sd_last, (exp_q.size() == 1));
            end else begin
                chk("sd_out_idle", sd_out, 1'b0);
                chk("sd_last_idle", sd_last, 1'b0);
            end
            seen_done = done_next;

            if (!hold) cap_req = 1'b0;
            // Junk while frozen before the snapshot edge, the word on the
            // snapshot edge, all ones afterwards.
            if (c == 1)      q_in = ~word;
            else if (c == 2) q_in = word;
            else             q_in = '1;

            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((c % 3) == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            sd_ready  = rdy;
            done_next = 1'b0;
            if (sd_valid && rdy && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                accepted++;
                if (exp_q.size() == 0) done_next = 1'b1;
            end
        end

        chk("frame_completed", seen_done, 1'b1);
        chk("bit_count", accepted, sle_rdbk_frame_len(W));
        @(negedge clk);
        chk_outputs_zero("idle_after");
        cap_req  = 1'b0;
        sd_ready = 1'b0;
        @(negedge clk);
        chk("stays_idle", busy, 1'b0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        cap_req  = 1'b1;
        q_in     = '0;
        sd_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst     = 1'b0;
        cap_req = 1'b0;
        @(negedge clk);
        chk_outputs_zero("idle");

        run_frame(16'hA5C3, 0, 1'b0, 0);
        run_frame(16'hA5C3, 1, 1'b0, 0);
        run_frame(16'hA5C3, 0, 1'b1, 0);
        run_frame(16'hA5C3, 0, 1'b0, 5);
        run_frame(16'hA5C3, 0, 1'b0, 0);
        run_frame(16'h0001, 0, 1'b0, 0);
        run_frame(16'hFFFF, 2, 1'b0, 0);
        for (int n = 0; n < 8; n++) begin
            run_frame(W'($urandom), 2, 1'($urandom_range(0, 1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
